// File: rtl/sk9822_pixel_buffer.sv
// Double-buffered LED pixel store feeding the SK9822 serializer. Each LED word it
// emits is {3'b111, bright, rgb}. A bank swap waits for the next frame_start.
`timescale 1ns/1ps
module sk9822_pixel_buffer #(
  parameter int unsigned LED_NUM        = 12,
  parameter int unsigned ADDR_W         = 4,
  parameter logic [4:0]  DEFAULT_BRIGHT = 5'b01111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic              wr_err,
  input  logic              bright_we,
  input  logic [4:0]        bright_in,
  input  logic              swap_req,
  output logic              swap_done,
  input  logic              frame_start,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [31:0]       pix_data,
  output logic              pix_last,
  output logic              frame_abort
);

  localparam int unsigned MemDepth = 2 * LED_NUM;
  localparam int unsigned MemAw    = $clog2(MemDepth);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(LED_NUM - 1);

  logic [23:0] mem [MemDepth];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              disp_bank_q;
  logic              swap_pend_q;
  logic [4:0]        bright_q;
  logic [31:0]       pix_data_q;
  logic              pix_last_q;
  logic              swap_done_q;
  logic              wr_err_q;
  logic              frame_abort_q;

  logic             wr_ok;
  logic             swap_now;
  logic             load_pix;
  logic             abort;
  logic [MemAw-1:0] wr_ptr;
  logic [MemAw-1:0] rd_ptr;

  assign wr_ok    = wr_en && (32'(wr_addr) < LED_NUM);
  assign swap_now = frame_start && (swap_pend_q || swap_req);

  // Bank b occupies mem[b*LED_NUM +: LED_NUM]; writes always target the hidden bank.
  assign wr_ptr = MemAw'(disp_bank_q ? 32'd0 : LED_NUM) + MemAw'(wr_addr);
  assign rd_ptr = MemAw'(disp_bank_q ? LED_NUM : 32'd0) + MemAw'(rd_idx_q);

  // RAM has no reset so an image survives rst.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    load_pix = 1'b0;
    abort    = 1'b0;
    case (state_q)
      StIdle: begin
        if (frame_start) begin
          rd_idx_d = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (frame_start) begin
          abort    = 1'b1;
          rd_idx_d = '0;
        end else begin
          load_pix = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        // A restart wins over an accept in the same cycle.
        if (frame_start) begin
          abort    = 1'b1;
          rd_idx_d = '0;
          state_d  = StFetch;
        end else if (pix_ready) begin
          if (rd_idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            state_d  = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rd_idx_q      <= '0;
      disp_bank_q   <= 1'b0;
      swap_pend_q   <= 1'b0;
      bright_q      <= DEFAULT_BRIGHT;
      pix_data_q    <= '0;
      pix_last_q    <= 1'b0;
      swap_done_q   <= 1'b0;
      wr_err_q      <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      if (swap_now) begin
        disp_bank_q <= ~disp_bank_q;
      end
      swap_pend_q <= swap_now ? 1'b0 : (swap_pend_q | swap_req);
      if (bright_we) begin
        bright_q <= bright_in;
      end
      if (load_pix) begin
        pix_data_q <= {3'b111, bright_q, mem[rd_ptr]};
        pix_last_q <= (rd_idx_q == LastIdx);
      end
      swap_done_q   <= swap_now;
      wr_err_q      <= wr_en && !wr_ok;
      frame_abort_q <= abort;
    end
  end

  assign pix_valid   = (state_q == StHold);
  assign pix_data    = pix_data_q;
  assign pix_last    = pix_last_q;
  assign swap_done   = swap_done_q;
  assign wr_err      = wr_err_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_sk9822_pixel_buffer.sv
// Bench for sk9822_pixel_buffer: randomized images checked against a bank/image model.
`timescale 1ns/1ps
module tb_sk9822_pixel_buffer;

  localparam int N  = 12;
  localparam int AW = 4;
  localparam logic [4:0] DEF_BRIGHT = 5'b01111;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          wr_err;
  logic          bright_we;
  logic [4:0]    bright_in;
  logic          swap_req;
  logic          swap_done;
  logic          frame_start;
  logic          pix_valid;
  logic          pix_ready;
  logic [31:0]   pix_data;
  logic          pix_last;
  logic          frame_abort;

  sk9822_pixel_buffer #(
    .LED_NUM       (N),
    .ADDR_W        (AW),
    .DEFAULT_BRIGHT(DEF_BRIGHT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .bright_we  (bright_we),
    .bright_in  (bright_in),
    .swap_req   (swap_req),
    .swap_done  (swap_done),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .frame_abort(frame_abort)
  );

  always #10 clk = ~clk;

  // Model: two images, which one is shown, pending swap, brightness, frame progress.
  logic [23:0] model_mem [2][N];
  int          model_disp;
  logic        model_pend;
  logic [4:0]  model_bright;
  bit          model_busy;
  int          cur_idx;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pix(input logic [AW-1:0] addr, input logic [23:0] data);
    logic exp_err;
    exp_err = (32'(addr) >= N);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
    n_tests++;
    if (wr_err !== exp_err) begin
      n_fail++;
      $display("FAIL wr_err addr=%0d: got %b, required %b", addr, wr_err, exp_err);
    end
    if (!exp_err) model_mem[1 - model_disp][addr] = data;
  endtask

  task automatic request_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    model_pend = 1'b1;
  endtask

  task automatic do_frame_start(input logic rdy, input logic with_swap);
    logic exp_swap, exp_abort;
    exp_swap  = model_pend | with_swap;
    exp_abort = model_busy;
    frame_start = 1'b1; swap_req = with_swap; pix_ready = rdy;
    tick();
    frame_start = 1'b0; swap_req = 1'b0; pix_ready = 1'b0;
    if (exp_swap) model_disp = 1 - model_disp;
    model_pend = 1'b0;
    n_tests++;
    if (swap_done !== exp_swap || frame_abort !== exp_abort || pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_start_t1: swap_done=%b abort=%b valid=%b, required %b %b 0",
               swap_done, frame_abort, pix_valid, exp_swap, exp_abort);
    end
    tick();
    n_tests++;
    if (swap_done !== 1'b0 || frame_abort !== 1'b0 || pix_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start_t2: swap_done=%b abort=%b valid=%b, required 0 0 1",
               swap_done, frame_abort, pix_valid);
    end
    model_busy = 1'b1;
    cur_idx    = 0;
  endtask

  // Accept words cur_idx..upto-1; optional stall, brightness load and swap request
  // on chosen words (brightness/swap ride on that word's accept cycle).
  task automatic recv_words(input int upto, input int stall_idx, input int stall_len,
                            input int bright_idx, input logic [4:0] nb, input int swap_idx);
    logic [31:0] exp_data;
    logic        exp_last;
    int          first, w, exp_w;
    first = cur_idx;
    for (int i = first; i < upto; i++) begin
      w = 0;
      while (pix_valid !== 1'b1 && w < 4) begin
        tick();
        w++;
      end
      exp_w = (i == first) ? 0 : 1;
      n_tests++;
      if (pix_valid !== 1'b1 || w != exp_w) begin
        n_fail++;
        $display("FAIL word%0d_latency: valid=%b after %0d cycles, required valid after %0d",
                 i, pix_valid, w, exp_w);
        if (pix_valid !== 1'b1) return;
      end
      exp_data = {3'b111, model_bright, model_mem[model_disp][i]};
      exp_last = (i == N - 1);
      n_tests++;
      if (pix_data !== exp_data) begin
        n_fail++;
        $display("FAIL word%0d_data: got %h, required %h", i, pix_data, exp_data);
      end
      n_tests++;
      if (pix_last !== exp_last) begin
        n_fail++;
        $display("FAIL word%0d_last: got %b, required %b", i, pix_last, exp_last);
      end
      if (i == stall_idx) begin
        for (int s = 0; s < stall_len; s++) begin
          tick();
          n_tests++;
          if (pix_valid !== 1'b1 || pix_data !== exp_data) begin
            n_fail++;
            $display("FAIL stall%0d: valid=%b data=%h, required 1 %h",
                     s, pix_valid, pix_data, exp_data);
          end
        end
      end
      pix_ready = 1'b1;
      bright_we = (i == bright_idx);
      bright_in = nb;
      swap_req  = (i == swap_idx);
      tick();
      pix_ready = 1'b0; bright_we = 1'b0; swap_req = 1'b0;
      if (i == bright_idx) model_bright = nb;
      if (i == swap_idx) model_pend = 1'b1;
      cur_idx = i + 1;
    end
    if (cur_idx == N) begin
      model_busy = 1'b0;
      tick();
      n_tests++;
      if (pix_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_end_idle: valid=%b, required 0", pix_valid);
      end
    end
  endtask

  task automatic model_reset();
    model_disp = 0; model_pend = 1'b0; model_bright = DEF_BRIGHT;
    model_busy = 1'b0; cur_idx = 0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (pix_valid !== 1'b0 || pix_data !== 32'h0 || pix_last !== 1'b0 ||
        swap_done !== 1'b0 || wr_err !== 1'b0 || frame_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h last=%b swap=%b err=%b abort=%b, required all 0",
               pix_valid, pix_data, pix_last, swap_done, wr_err, frame_abort);
    end
    rst = 1'b0;
    tick();
    do_frame_start(1'b0, 1'b0);
    recv_words(N, -1, 0, -1, 5'h0, -1);
  endtask

  task automatic test_swap();
    write_pix(4'd0, 24'h000001);
    write_pix(4'd11, 24'hFF0000);
    request_swap();
    request_swap();
    do_frame_start(1'b0, 1'b0);
    recv_words(N, -1, 0, -1, 5'h0, -1);
    do_frame_start(1'b0, 1'b0);
    recv_words(N, -1, 0, -1, 5'h0, -1);
    write_pix(4'd5, $urandom());
    do_frame_start(1'b0, 1'b1);
    recv_words(N, -1, 0, -1, 5'h0, -1);
  endtask

  task automatic test_bright();
    do_frame_start(1'b0, 1'b0);
    recv_words(N, -1, 0, 4, 5'h1F, -1);
  endtask

  task automatic test_stall();
    do_frame_start(1'b0, 1'b0);
    recv_words(N, 3, 10, -1, 5'h0, -1);
  endtask

  task automatic test_abort();
    for (int k = 0; k < N; k++) write_pix(AW'(k), $urandom());
    do_frame_start(1'b0, 1'b0);
    recv_words(7, -1, 0, -1, 5'h0, 2);
    tick();
    n_tests++;
    if (pix_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_valid: got %b, required 1", pix_valid);
    end
    do_frame_start(1'b1, 1'b0);
    recv_words(N, -1, 0, -1, 5'h0, -1);
  endtask

  task automatic test_wr_err();
    write_pix(4'd12, $urandom());
    write_pix(4'd15, $urandom());
    write_pix(4'd3, $urandom());
    request_swap();
    do_frame_start(1'b0, 1'b0);
    recv_words(N, -1, 0, -1, 5'h0, -1);
    write_pix(4'd13, $urandom());
    do_frame_start(1'b0, 1'b1);
    recv_words(N, -1, 0, -1, 5'h0, -1);
  endtask

  task automatic test_reset_mid();
    do_frame_start(1'b0, 1'b0);
    recv_words(2, -1, 0, -1, 5'h0, -1);
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (pix_valid !== 1'b0 || pix_data !== 32'h0 || pix_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b data=%h last=%b, required 0 0 0",
               pix_valid, pix_data, pix_last);
    end
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    do_frame_start(1'b0, 1'b0);
    recv_words(N, -1, 0, -1, 5'h0, -1);
    request_swap();
    do_frame_start(1'b0, 1'b0);
    recv_words(N, -1, 0, -1, 5'h0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) write_pix(AW'($urandom_range(0, 15)), $urandom());
      if ($urandom_range(0, 1) == 1) request_swap();
      do_frame_start(1'b0, 1'($urandom_range(0, 1)));
      recv_words(N, $urandom_range(0, N - 1), $urandom_range(1, 4),
                 $urandom_range(0, N - 1), 5'($urandom()), -1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    bright_we = 1'b0; bright_in = '0; swap_req = 1'b0;
    frame_start = 1'b0; pix_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < N; k++) model_mem[b][k] = 24'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_swap();
    test_bright();
    test_stall();
    test_abort();
    test_wr_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
